// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer.
//   - wb_exc bit positions (as presented by the WB stage)
//   - exc_type bit positions (one-hot cause handed to CP0)
//   - FSM state encodings
//   - default handler entry PC (BEV=1)
package exc_ctrl_pkg;

  // wb_exc = {adel_if, ri, ov, sys, bp, adel_d, ades}; priority falls with the index.
  localparam int unsigned WbAdelIf = 6;
  localparam int unsigned WbRi     = 5;
  localparam int unsigned WbOv     = 4;
  localparam int unsigned WbSys    = 3;
  localparam int unsigned WbBp     = 2;
  localparam int unsigned WbAdelD  = 1;
  localparam int unsigned WbAdes   = 0;

  // exc_type = {int, adel, ades, sys, bp, ri, ov}
  localparam int unsigned ExcInt  = 6;
  localparam int unsigned ExcAdel = 5;
  localparam int unsigned ExcAdes = 4;
  localparam int unsigned ExcSys  = 3;
  localparam int unsigned ExcBp   = 2;
  localparam int unsigned ExcRi   = 1;
  localparam int unsigned ExcOv   = 0;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StCommit   = 2'd1;
  localparam logic [1:0] StDrain    = 2'd2;
  localparam logic [1:0] StRedirect = 2'd3;

  localparam logic [31:0] ExcVectorDefault = 32'hBFC0_0380;

  typedef logic [6:0] wb_exc_t;
  typedef logic [6:0] exc_type_t;

endpackage

// File: rtl/exc_ctrl_if.sv
// Bundle of WB-side, CP0-side and fetch-redirect signals around exc_ctrl.
//   master : pipeline/CP0/fetch environment (drives wb_*, int_happen, cp0_epc, mem_busy,
//            redirect_ready)
//   slave  : exc_ctrl (drives wb_ready, exc_*, eret, flush, redirect_*, drain_timeout)
interface exc_ctrl_if;
  import exc_ctrl_pkg::*;

  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc;
  logic        wb_is_slot;
  wb_exc_t     wb_exc;
  logic [31:0] wb_bad_vaddr;
  logic        wb_eret;
  logic        int_happen;
  logic [31:0] cp0_epc;
  logic        mem_busy;
  exc_type_t   exc_type;
  logic [31:0] exc_pc;
  logic        exc_is_slot;
  logic [31:0] exc_bad_vaddr;
  logic        eret;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        drain_timeout;

  modport master (
    output wb_valid, wb_pc, wb_is_slot, wb_exc, wb_bad_vaddr, wb_eret, int_happen, cp0_epc,
           mem_busy, redirect_ready,
    input  wb_ready, exc_type, exc_pc, exc_is_slot, exc_bad_vaddr, eret, flush,
           redirect_valid, redirect_pc, drain_timeout
  );

  modport slave (
    input  wb_valid, wb_pc, wb_is_slot, wb_exc, wb_bad_vaddr, wb_eret, int_happen, cp0_epc,
           mem_busy, redirect_ready,
    output wb_ready, exc_type, exc_pc, exc_is_slot, exc_bad_vaddr, eret, flush,
           redirect_valid, redirect_pc, drain_timeout
  );

endinterface

// File: rtl/exc_ctrl_prio_enc.sv
// Combinational cause picker: interrupt request + wb_exc vector -> one-hot exc_type and the
// matching bad virtual address.
//   int_req_i      : interrupt request (already gated by configuration)
//   wb_exc_i       : raw exception flags from WB
//   wb_pc_i        : WB PC (bad address for instruction-fetch adel)
//   wb_bad_vaddr_i : data address (bad address for adel_d/ades)
//   exc_type_o     : one-hot winning cause, zero when none
//   bad_vaddr_o    : bad address for the winning cause, zero otherwise
//   exc_any_o      : any cause selected
module exc_ctrl_prio_enc
  import exc_ctrl_pkg::*;
(
  input  logic        int_req_i,
  input  wb_exc_t     wb_exc_i,
  input  logic [31:0] wb_pc_i,
  input  logic [31:0] wb_bad_vaddr_i,
  output exc_type_t   exc_type_o,
  output logic [31:0] bad_vaddr_o,
  output logic        exc_any_o
);

  always_comb begin
    exc_type_o  = '0;
    bad_vaddr_o = '0;
    if (int_req_i) begin
      exc_type_o[ExcInt] = 1'b1;
    end else if (wb_exc_i[WbAdelIf]) begin
      exc_type_o[ExcAdel] = 1'b1;
      bad_vaddr_o         = wb_pc_i;
    end else if (wb_exc_i[WbRi]) begin
      exc_type_o[ExcRi] = 1'b1;
    end else if (wb_exc_i[WbOv]) begin
      exc_type_o[ExcOv] = 1'b1;
    end else if (wb_exc_i[WbSys]) begin
      exc_type_o[ExcSys] = 1'b1;
    end else if (wb_exc_i[WbBp]) begin
      exc_type_o[ExcBp] = 1'b1;
    end else if (wb_exc_i[WbAdelD]) begin
      exc_type_o[ExcAdel] = 1'b1;
      bad_vaddr_o         = wb_bad_vaddr_i;
    end else if (wb_exc_i[WbAdes]) begin
      exc_type_o[ExcAdes] = 1'b1;
      bad_vaddr_o         = wb_bad_vaddr_i;
    end
  end

  assign exc_any_o = |exc_type_o;

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between WB and CP0.
// Captures an exception/ERET/interrupt event at WB, pulses the CP0 update for one cycle,
// flushes the pipeline, waits for outstanding memory traffic (bounded by DRAIN_MAX), then
// offers a redirect PC to fetch under valid/ready.
//   clk, resetn : clock and synchronous active-low reset
//   bus         : exc_ctrl_if.slave (WB event in, CP0 update out, fetch redirect handshake)
// Build option: define EXC_CTRL_INT_EN to let int_happen take part with top priority;
// otherwise int_happen is ignored and exc_type[6] stays 0.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = ExcVectorDefault,
  parameter int unsigned DRAIN_MAX  = 15
) (
  input  logic       clk,
  input  logic       resetn,
  exc_ctrl_if.slave  bus
);

  localparam int unsigned CntW = ($clog2(DRAIN_MAX + 1) > 4) ? $clog2(DRAIN_MAX + 1) : 4;
  localparam logic [CntW-1:0] CntMax = CntW'(DRAIN_MAX);

  logic int_req;
`ifdef EXC_CTRL_INT_EN
  assign int_req = bus.int_happen;
`else
  logic unused_int_happen;
  assign int_req           = 1'b0;
  assign unused_int_happen = bus.int_happen;
`endif

  exc_type_t   enc_type;
  logic [31:0] enc_bad_vaddr;
  logic        enc_any;

  exc_ctrl_prio_enc u_prio_enc (
    .int_req_i      (int_req),
    .wb_exc_i       (bus.wb_exc),
    .wb_pc_i        (bus.wb_pc),
    .wb_bad_vaddr_i (bus.wb_bad_vaddr),
    .exc_type_o     (enc_type),
    .bad_vaddr_o    (enc_bad_vaddr),
    .exc_any_o      (enc_any)
  );

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  exc_type_t       type_q, type_d;
  logic            eret_q, eret_d;
  logic [31:0]     pc_q, pc_d;
  logic            slot_q, slot_d;
  logic [31:0]     bad_q, bad_d;
  logic [31:0]     target_q, target_d;
  logic            timeout_q, timeout_d;

  logic wb_ready;
  logic event_hit;

  assign wb_ready  = (state_q == StIdle);
  assign event_hit = bus.wb_valid && wb_ready && (int_req || (|bus.wb_exc) || bus.wb_eret);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    type_d    = type_q;
    eret_d    = eret_q;
    pc_d      = pc_q;
    slot_d    = slot_q;
    bad_d     = bad_q;
    target_d  = target_q;
    timeout_d = timeout_q;
    case (state_q)
      StIdle: begin
        if (event_hit) begin
          state_d  = StCommit;
          type_d   = enc_type;
          // An exception on the same instruction overrides its ERET.
          eret_d   = bus.wb_eret && !enc_any;
          pc_d     = bus.wb_pc;
          slot_d   = bus.wb_is_slot;
          bad_d    = enc_bad_vaddr;
          target_d = enc_any ? EXC_VECTOR : bus.cp0_epc;
        end
      end
      StCommit: begin
        state_d = StDrain;
        cnt_d   = '0;
      end
      StDrain: begin
        if (!bus.mem_busy || (cnt_q == CntMax)) begin
          state_d = StRedirect;
          // Only a forced exit (bus still busy at the limit) counts as a timeout.
          if (bus.mem_busy) begin
            timeout_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRedirect: begin
        if (bus.redirect_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      type_q    <= '0;
      eret_q    <= 1'b0;
      pc_q      <= '0;
      slot_q    <= 1'b0;
      bad_q     <= '0;
      target_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      type_q    <= type_d;
      eret_q    <= eret_d;
      pc_q      <= pc_d;
      slot_q    <= slot_d;
      bad_q     <= bad_d;
      target_q  <= target_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.wb_ready       = wb_ready;
  assign bus.exc_type       = (state_q == StCommit) ? type_q : '0;
  assign bus.eret           = (state_q == StCommit) && eret_q;
  assign bus.exc_pc         = pc_q;
  assign bus.exc_is_slot    = slot_q;
  assign bus.exc_bad_vaddr  = bad_q;
  assign bus.flush          = (state_q != StIdle);
  assign bus.redirect_valid = (state_q == StRedirect);
  assign bus.redirect_pc    = target_q;
  assign bus.drain_timeout  = timeout_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus randomized events against a
// cause-priority / cycle-schedule reference model.
module tb_exc_ctrl;

  localparam logic [31:0] Vec     = 32'hBFC0_0380;
  localparam int          DrainMx = 15;
`ifdef EXC_CTRL_INT_EN
  localparam bit IntEn = 1'b1;
`else
  localparam bit IntEn = 1'b0;
`endif

  logic clk;
  logic resetn;
  int   checks;
  int   failures;
  logic exp_to;

  exc_ctrl_if bus_if ();

  exc_ctrl #(
    .EXC_VECTOR (Vec),
    .DRAIN_MAX  (DrainMx)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Winning cause: 7 = interrupt, 6..0 = wb_exc bit index, -1 = none.
  function automatic int model_cause(input logic [6:0] exc, input logic intr);
    if (intr) return 7;
    for (int i = 6; i >= 0; i--) begin
      if (exc[i]) return i;
    end
    return -1;
  endfunction

  // exc_type = {int, adel, ades, sys, bp, ri, ov}
  function automatic logic [6:0] model_type(input int cause);
    logic [6:0] t;
    t = '0;
    case (cause)
      7:       t[6] = 1'b1;
      6, 1:    t[5] = 1'b1;
      0:       t[4] = 1'b1;
      3:       t[3] = 1'b1;
      2:       t[2] = 1'b1;
      5:       t[1] = 1'b1;
      4:       t[0] = 1'b1;
      default: t = '0;
    endcase
    return t;
  endfunction

  task automatic idle_inputs();
    bus_if.wb_valid       = 1'b0;
    bus_if.wb_pc          = '0;
    bus_if.wb_is_slot     = 1'b0;
    bus_if.wb_exc         = '0;
    bus_if.wb_bad_vaddr   = '0;
    bus_if.wb_eret        = 1'b0;
    bus_if.int_happen     = 1'b0;
    bus_if.cp0_epc        = '0;
    bus_if.mem_busy       = 1'b0;
    bus_if.redirect_ready = 1'b0;
  endtask

  // One full event: b = DRAIN cycles with mem_busy high, r = REDIRECT cycles with ready low.
  task automatic run_event(input string name, input logic [6:0] exc, input logic er,
                           input logic intr, input logic [31:0] pc, input logic slot,
                           input logic [31:0] bad, input logic [31:0] epc, input int b,
                           input int r);
    int          cause;
    logic [6:0]  et;
    logic        any;
    logic        exp_eret;
    logic [31:0] ebad;
    logic [31:0] tgt;
    int          d;
    int          last;
    logic        to;
    int          k;
    int          j;
    cause    = model_cause(exc, intr && IntEn);
    et       = model_type(cause);
    any      = (cause >= 0);
    exp_eret = er && !any;
    ebad     = (cause == 6) ? pc : ((cause == 1 || cause == 0) ? bad : 32'h0);
    tgt      = any ? Vec : epc;
    d        = (b + 1 < DrainMx + 1) ? b + 1 : DrainMx + 1;
    to       = (b >= DrainMx + 1);
    last     = 2 + d + r;

    @(negedge clk);
    checks++;
    if (bus_if.wb_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s pre wb_ready: got %b want 1", name, bus_if.wb_ready);
    end
    bus_if.wb_valid     = 1'b1;
    bus_if.wb_exc       = exc;
    bus_if.wb_eret      = er;
    bus_if.int_happen   = intr;
    bus_if.wb_pc        = pc;
    bus_if.wb_is_slot   = slot;
    bus_if.wb_bad_vaddr = bad;
    bus_if.cp0_epc      = epc;
    bus_if.mem_busy     = 1'b0;

    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      k = c - 1;
      j = c - 1 - d;
      checks++;
      if (bus_if.wb_ready !== 1'b0 || bus_if.flush !== 1'b1) begin
        failures++;
        $display("FAIL %s c%0d ready/flush: got %b/%b want 0/1", name, c, bus_if.wb_ready,
                 bus_if.flush);
      end
      if (c == 1) begin
        checks++;
        if (bus_if.exc_type !== et || bus_if.eret !== exp_eret) begin
          failures++;
          $display("FAIL %s commit type/eret: got %b/%b want %b/%b", name, bus_if.exc_type,
                   bus_if.eret, et, exp_eret);
        end
        checks++;
        if (bus_if.exc_pc !== pc || bus_if.exc_is_slot !== slot ||
            bus_if.exc_bad_vaddr !== ebad) begin
          failures++;
          $display("FAIL %s commit pc/slot/bad: got %h/%b/%h want %h/%b/%h", name,
                   bus_if.exc_pc, bus_if.exc_is_slot, bus_if.exc_bad_vaddr, pc, slot, ebad);
        end
        checks++;
        if (bus_if.redirect_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s commit redirect_valid: got %b want 0", name, bus_if.redirect_valid);
        end
      end else begin
        checks++;
        if (bus_if.exc_type !== 7'd0 || bus_if.eret !== 1'b0) begin
          failures++;
          $display("FAIL %s c%0d type/eret idle: got %b/%b want 0/0", name, c,
                   bus_if.exc_type, bus_if.eret);
        end
      end
      if (c >= 2 && c <= 1 + d) begin
        checks++;
        if (bus_if.redirect_valid !== 1'b0 || bus_if.drain_timeout !== exp_to) begin
          failures++;
          $display("FAIL %s drain%0d valid/timeout: got %b/%b want 0/%b", name, k,
                   bus_if.redirect_valid, bus_if.drain_timeout, exp_to);
        end
      end
      if (c >= 2 + d) begin
        checks++;
        if (bus_if.redirect_valid !== 1'b1 || bus_if.redirect_pc !== tgt ||
            bus_if.drain_timeout !== (exp_to | to)) begin
          failures++;
          $display("FAIL %s redirect%0d valid/pc/timeout: got %b/%h/%b want 1/%h/%b", name, j,
                   bus_if.redirect_valid, bus_if.redirect_pc, bus_if.drain_timeout, tgt,
                   exp_to | to);
        end
      end
      // Garbage on WB and early ready pulses must be ignored outside IDLE/REDIRECT.
      bus_if.wb_valid   = 1'($urandom_range(0, 1));
      bus_if.wb_exc     = 7'($urandom_range(0, 127));
      bus_if.wb_eret    = 1'($urandom_range(0, 1));
      bus_if.int_happen = 1'($urandom_range(0, 1));
      if (c >= 2 && c <= 1 + d) bus_if.mem_busy = (k <= b);
      else bus_if.mem_busy = 1'($urandom_range(0, 1));
      if (c >= 2 + d) bus_if.redirect_ready = (j == r + 1);
      else bus_if.redirect_ready = 1'($urandom_range(0, 1));
    end
    exp_to = exp_to | to;

    @(negedge clk);
    checks++;
    if (bus_if.wb_ready !== 1'b1 || bus_if.flush !== 1'b0 || bus_if.redirect_valid !== 1'b0 ||
        bus_if.drain_timeout !== exp_to) begin
      failures++;
      $display("FAIL %s back-to-idle ready/flush/valid/timeout: got %b/%b/%b/%b want 1/0/0/%b",
               name, bus_if.wb_ready, bus_if.flush, bus_if.redirect_valid,
               bus_if.drain_timeout, exp_to);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    exp_to = 1'b0;
    checks++;
    if (bus_if.wb_ready !== 1'b1 || bus_if.flush !== 1'b0 || bus_if.redirect_valid !== 1'b0 ||
        bus_if.exc_type !== 7'd0 || bus_if.eret !== 1'b0 || bus_if.drain_timeout !== 1'b0 ||
        bus_if.redirect_pc !== 32'h0 || bus_if.exc_pc !== 32'h0 ||
        bus_if.exc_bad_vaddr !== 32'h0 || bus_if.exc_is_slot !== 1'b0) begin
      failures++;
      $display("FAIL reset outputs: got rdy=%b fl=%b rv=%b t=%b e=%b to=%b rpc=%h want 1,0,0,0,0,0,0",
               bus_if.wb_ready, bus_if.flush, bus_if.redirect_valid, bus_if.exc_type,
               bus_if.eret, bus_if.drain_timeout, bus_if.redirect_pc);
    end
    resetn = 1'b1;
  endtask

  task automatic test_basic();
    run_event("ov", 7'b0010000, 1'b0, 1'b0, 32'h8000_0100, 1'b0, 32'h0, 32'h0, 0, 0);
    run_event("ri_ades", 7'b0100001, 1'b0, 1'b0, 32'h8000_0104, 1'b1, 32'h0000_1234,
              32'h0, 0, 0);
    run_event("eret", 7'b0000000, 1'b1, 1'b0, 32'h8000_0108, 1'b0, 32'h0, 32'h8000_0200, 0, 0);
    run_event("eret_vs_bp", 7'b0000100, 1'b1, 1'b0, 32'h8000_010C, 1'b0, 32'h0,
              32'h8000_0300, 0, 0);
    run_event("adel_if", 7'b1000010, 1'b0, 1'b0, 32'h8000_0111, 1'b0, 32'hDEAD_0000,
              32'h0, 0, 0);
  endtask

  task automatic test_drain();
    run_event("drain5", 7'b0000010, 1'b0, 1'b0, 32'h8000_0120, 1'b0, 32'h0000_0ABD,
              32'h0, 5, 0);
    run_event("drain_stuck", 7'b0000001, 1'b0, 1'b0, 32'h8000_0124, 1'b0, 32'h0000_0AB2,
              32'h0, 40, 0);
  endtask

  task automatic test_ready_stall();
    run_event("stall4", 7'b0001000, 1'b0, 1'b0, 32'h8000_0130, 1'b1, 32'h0, 32'h0, 2, 4);
  endtask

  task automatic test_int();
    run_event("int_ri", 7'b0100000, 1'b0, 1'b1, 32'h8000_0140, 1'b0, 32'h0, 32'h0, 1, 1);
    // int_happen without wb_valid never starts a sequence.
    @(negedge clk);
    bus_if.int_happen = 1'b1;
    bus_if.wb_exc     = 7'b0010000;
    bus_if.wb_valid   = 1'b0;
    @(negedge clk);
    checks++;
    if (bus_if.wb_ready !== 1'b1 || bus_if.flush !== 1'b0) begin
      failures++;
      $display("FAIL int_no_valid ready/flush: got %b/%b want 1/0", bus_if.wb_ready,
               bus_if.flush);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    bus_if.wb_valid = 1'b1;
    bus_if.wb_exc   = 7'b0000100;
    bus_if.wb_pc    = 32'h8000_0150;
    @(negedge clk);
    idle_inputs();
    bus_if.mem_busy = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (bus_if.flush !== 1'b1 || bus_if.redirect_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid in drain flush/valid: got %b/%b want 1/0", bus_if.flush,
               bus_if.redirect_valid);
    end
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_to = 1'b0;
    checks++;
    if (bus_if.wb_ready !== 1'b1 || bus_if.flush !== 1'b0 || bus_if.redirect_valid !== 1'b0 ||
        bus_if.drain_timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid after reset rdy/flush/valid/to: got %b/%b/%b/%b want 1/0/0/0",
               bus_if.wb_ready, bus_if.flush, bus_if.redirect_valid, bus_if.drain_timeout);
    end
    bus_if.mem_busy = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_if.redirect_valid === 1'b1 || bus_if.flush === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_mid stray activity cycles: got %0d want 0", seen);
    end
  endtask

  task automatic test_random();
    logic [6:0]  exc;
    logic        er;
    logic        intr;
    logic        vld;
    for (int n = 0; n < 40; n++) begin
      exc  = 7'($urandom_range(0, 127)) & 7'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) exc = '0;
      er   = ($urandom_range(0, 2) == 0);
      intr = ($urandom_range(0, 3) == 0);
      vld  = ($urandom_range(0, 7) != 0);
      if (vld && ((intr && IntEn) || (|exc) || er)) begin
        run_event("rand", exc, er, intr, $urandom, 1'($urandom_range(0, 1)), $urandom,
                  $urandom, $urandom_range(0, 20), $urandom_range(0, 3));
      end else begin
        @(negedge clk);
        bus_if.wb_valid   = vld;
        bus_if.wb_exc     = exc;
        bus_if.wb_eret    = er;
        bus_if.int_happen = intr;
        @(negedge clk);
        checks++;
        if (bus_if.wb_ready !== 1'b1 || bus_if.flush !== 1'b0) begin
          failures++;
          $display("FAIL rand no-event ready/flush: got %b/%b want 1/0", bus_if.wb_ready,
                   bus_if.flush);
        end
        idle_inputs();
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    exp_to   = 1'b0;
    resetn   = 1'b0;
    idle_inputs();
    test_reset();
    test_basic();
    test_drain();
    test_ready_stall();
    test_int();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
